// File: rtl/mpu_table_writer_if.sv
// Interface for mpu_table_writer: the command port toward the configuring
// master and the memory initiator port toward the arbiter.
interface mpu_table_writer_if #(
    parameter int IDX_W = 4
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_op;
    logic [IDX_W-1:0] cfg_index;
    logic [31:0]      cfg_pc_lo;
    logic [31:0]      cfg_perm;
    logic [31:0]      cfg_pc_hi;
    logic [31:0]      cfg_data_lo;
    logic [31:0]      cfg_data_hi;
    logic             cfg_done;
    logic             cfg_err;
    logic             busy;
    logic             mem_req;
    logic             mem_gnt;
    logic [3:0]       mem_wen;
    logic [21:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mpu_inval;

    // Writer side
    modport slave (
        input  cfg_valid, cfg_op, cfg_index, cfg_pc_lo, cfg_perm, cfg_pc_hi,
               cfg_data_lo, cfg_data_hi, mem_gnt, mem_rdata,
        output cfg_ready, cfg_done, cfg_err, busy, mem_req, mem_wen,
               mem_addr, mem_wdata, mpu_inval
    );

    // Configuring master / memory side
    modport master (
        output cfg_valid, cfg_op, cfg_index, cfg_pc_lo, cfg_perm, cfg_pc_hi,
               cfg_data_lo, cfg_data_hi, mem_gnt, mem_rdata,
        input  cfg_ready, cfg_done, cfg_err, busy, mem_req, mem_wen,
               mem_addr, mem_wdata, mpu_inval
    );
endinterface

// File: rtl/mpu_table_writer.sv
// mpu_table_writer: programs the MPU rule table in main memory. One command
// writes a single 5-word entry or clears every entry, optionally reads each
// word back for verification, and pulses mpu_inval so mem_mpu reloads.
module mpu_table_writer #(
    parameter int MPU_START_ADDR = 768,
    parameter int MPU_ITEM_NUM   = 16,
    parameter int MPU_ITEM_LEN   = 5,
    parameter int IDX_W          = 4,
    parameter int VERIFY         = 1
) (
    input logic               clk,
    input logic               reset,
    mpu_table_writer_if.slave bus
);
    localparam logic [21:0]      START_A  = 22'(MPU_START_ADDR);
    localparam logic [21:0]      LEN_A    = 22'(MPU_ITEM_LEN);
    localparam logic [2:0]       W_LAST   = 3'(MPU_ITEM_LEN - 1);
    localparam logic [IDX_W-1:0] ENT_LAST = IDX_W'(MPU_ITEM_NUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RDBK, S_DONE, S_ERR} state_t;

    state_t           state_q, state_d;
    logic [2:0]       w_q, w_d;          // word within the entry
    logic [IDX_W-1:0] ent_q, ent_d;      // entry being addressed
    logic [1:0]       ph_q, ph_d;        // readback phase: addr, wait, compare
    logic             op_q, op_d;        // 1 = clear all
    logic             wrote_q, wrote_d;  // any word committed to memory
    logic [31:0]      word_q [5];        // latched entry contents

    logic [31:0]      word_c;
    logic [21:0]      addr_c;
    logic [31:0]      idx_ext;
    logic             idx_bad;
    logic             last_word, last_item, seq_end;
    logic [2:0]       nxt_w;
    logic [IDX_W-1:0] nxt_ent;

    logic             ready_c, done_c, err_c, busy_c, req_c, inval_c;
    logic [3:0]       wen_c;
    logic [21:0]      maddr_c;
    logic [31:0]      wdata_c;

    assign addr_c    = START_A + 22'(ent_q) * LEN_A + 22'(w_q);
    assign idx_ext   = 32'(bus.cfg_index);
    assign idx_bad   = !bus.cfg_op && (idx_ext >= 32'(MPU_ITEM_NUM));
    assign last_word = (w_q == W_LAST);
    assign last_item = !op_q || (ent_q == ENT_LAST);

    // Control state register; an in-flight command is abandoned on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            ent_q   <= '0;
            ph_q    <= '0;
            op_q    <= 1'b0;
            wrote_q <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            ent_q   <= ent_d;
            ph_q    <= ph_d;
            op_q    <= op_d;
            wrote_q <= wrote_d;
        end
    end

    // Capture the entry payload at command acceptance
    always_ff @(posedge clk) begin
        if (bus.cfg_valid && state_q == S_IDLE) begin
            word_q[0] <= bus.cfg_pc_lo;
            word_q[1] <= bus.cfg_perm;
            word_q[2] <= bus.cfg_pc_hi;
            word_q[3] <= bus.cfg_data_lo;
            word_q[4] <= bus.cfg_data_hi;
        end
    end

    // Word value for the current position; a cleared entry has lo > hi
    always_comb begin
        word_c = '0;
        if (op_q) begin
            word_c = (w_q == 3'd0) ? 32'hFFFF_FFFF : 32'h0;
        end else begin
            case (w_q)
                3'd0:    word_c = word_q[0];
                3'd1:    word_c = word_q[1];
                3'd2:    word_c = word_q[2];
                3'd3:    word_c = word_q[3];
                3'd4:    word_c = word_q[4];
                default: word_c = '0;
            endcase
        end
    end

    // Position advance shared by the write and readback passes
    always_comb begin
        nxt_w   = w_q + 3'd1;
        nxt_ent = ent_q;
        seq_end = 1'b0;
        if (last_word) begin
            nxt_w = '0;
            if (last_item) begin
                seq_end = 1'b1;
                nxt_ent = op_q ? '0 : ent_q;  // rewind for the readback pass
            end else begin
                nxt_ent = ent_q + IDX_W'(1);
            end
        end
    end

    // Next state and outputs
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        ent_d   = ent_q;
        ph_d    = ph_q;
        op_d    = op_q;
        wrote_d = wrote_q;
        ready_c = 1'b0;
        done_c  = 1'b0;
        err_c   = 1'b0;
        busy_c  = 1'b1;
        req_c   = 1'b0;
        inval_c = 1'b0;
        wen_c   = 4'h0;
        maddr_c = '0;
        wdata_c = '0;
        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                busy_c  = 1'b0;
                if (bus.cfg_valid) begin
                    op_d    = bus.cfg_op;
                    ent_d   = bus.cfg_op ? '0 : bus.cfg_index;
                    w_d     = '0;
                    ph_d    = '0;
                    wrote_d = 1'b0;
                    state_d = idx_bad ? S_ERR : S_WRITE;
                end
            end
            S_WRITE: begin
                req_c   = 1'b1;
                maddr_c = addr_c;
                wdata_c = word_c;
                if (bus.mem_gnt) begin
                    wen_c   = 4'hF;
                    wrote_d = 1'b1;
                    w_d     = nxt_w;
                    ent_d   = nxt_ent;
                    if (seq_end) state_d = (VERIFY != 0) ? S_RDBK : S_DONE;
                end
            end
            S_RDBK: begin
                req_c   = 1'b1;
                maddr_c = addr_c;
                if (!bus.mem_gnt) begin
                    ph_d = 2'd0;
                end else begin
                    case (ph_q)
                        2'd0:    ph_d = 2'd1;
                        2'd1:    ph_d = 2'd2;
                        default: begin
                            if (bus.mem_rdata != word_c) begin
                                state_d = S_ERR;
                            end else begin
                                ph_d  = 2'd0;
                                w_d   = nxt_w;
                                ent_d = nxt_ent;
                                if (seq_end) state_d = S_DONE;
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                inval_c = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_c   = 1'b1;
                inval_c = wrote_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cfg_ready = ready_c;
    assign bus.cfg_done  = done_c;
    assign bus.cfg_err   = err_c;
    assign bus.busy      = busy_c;
    assign bus.mem_req   = req_c;
    assign bus.mem_wen   = wen_c;
    assign bus.mem_addr  = maddr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.mpu_inval = inval_c;
endmodule
